fetch_bus_sequencer: RTL
========================

# fetch_bus_sequencer

Control-step sequencer that owns the datapath bus-source selection during instruction fetch and hands it to the execute sequencer afterwards. Produces the 24-bit one-hot bus-source vector consumed by the bus encoder (5-bit select → bus mux), plus the fetch register-load strobes. Handles the memory-read handshake with a timeout and polices the one-hot rule on the execute sequencer's source requests.

## Interface
- MEM_TIMEOUT, 15: T1W cycles waiting for mem_ready before FAULT (1–255).
- clock  in  1  system clock, rising edge.
- clear  in  1  asynchronous, active-high reset.
- run  in  1  level; permits leaving IDLE and starting the next fetch.
- halt  in  1  sampled with exec_done; forces return to IDLE.
- mem_ready  in  1  memory read data valid on MDR input.
- exec_bus_sel  in  24  bus-source request from the execute sequencer, used only in EXEC.
- exec_done  in  1  execute sequencer finished the current instruction.
- bus_out_sel  out  24  one-hot bus source. Bits 0–15 R0–R15out, 16 HIout, 17 LOout, 18 Zhighout, 19 Zlowout, 20 PCout, 21 MDRout, 22 InPortout, 23 Cout.
- mar_in, inc_pc, z_in, pc_in, mem_read, mdr_in, ir_in  out  1 each  fetch load strobes.
- ir_valid  out  1  high throughout EXEC.
- exec_start  out  1  one-cycle pulse on the first EXEC cycle.
- mem_err  out  1  sticky; set on entering FAULT.
- bus_conflict  out  1  combinational; exec_bus_sel has more than one bit set in EXEC.
- conflict_count  out  8  saturating count of bus_conflict cycles.
- state  out  3  IDLE=0, T0=1, T1=2, T1W=3, T2=4, EXEC=5, FAULT=6.

## Operation
- The only registers are the 3-bit state, the 8-bit wait counter, exec_start, mem_err and conflict_count. Strobes are Moore decodes of state, except mdr_in and bus_out_sel in EXEC.
- IDLE: all outputs 0. run=1 → T0.
- T0: bus_out_sel bit20 (PCout), mar_in, inc_pc, z_in → T1.
- T1: bit19 (Zlowout), pc_in → T1W. Clear the wait counter.
- T1W: mem_read=1; mdr_in = mem_ready; bus_out_sel=0.
  - mem_ready=1 → T2.
  - Otherwise increment the counter. At MEM_TIMEOUT cycles with no mem_ready → FAULT.
- T2: bit21 (MDRout), ir_in → EXEC. exec_start is set for the next cycle.
- EXEC: ir_valid=1.
  - bus_out_sel = exec_bus_sel when it has zero or one bit set.
  - With two or more bits set: bus_out_sel=0, bus_conflict=1, conflict_count increments (saturates at 255).
  - exec_done=1 → IDLE if halt=1 or run=0, else T0.
- FAULT: all strobes 0, mem_err=1. Leaves only via clear.
- Precedence and boundaries:
  - exec_done together with halt → IDLE.
  - mem_ready outside T1W is ignored. exec_done outside EXEC is ignored.
  - run falling mid-fetch does not abort; it is only examined at exec_done.
  - mem_ready arriving on the cycle the counter reaches MEM_TIMEOUT wins → T2.
- clear at any time: state=IDLE, counter=0, mem_err=0, conflict_count=0, exec_start=0. All outputs are 0 immediately, without waiting for a clock edge.

## Timing
- Reset values: every output 0; state=IDLE.
- Fetch latency with mem_ready already high: IDLE→T0 on the edge where run=1 is seen, then T1, T1W (1 cycle), T2, EXEC. ir_valid rises 4 edges after leaving IDLE.
- Each cycle mem_ready is low in T1W adds one cycle to the fetch.
- exec_start is high exactly on the first EXEC cycle.
- Back-to-back instructions: the cycle after exec_done is T0. No idle bubble.
- bus_out_sel is never multi-hot in any state.

## Test plan
- Reset then run=1, mem_ready=1: state sequence 1,2,3,4,5. bus_out_sel sequence 0x100000, 0x080000, 0, 0x200000, then exec_bus_sel. exec_start is high for one cycle.
- mem_ready held low for 3 cycles in T1W: T1W lasts 4 cycles. mdr_in is high only on the last one. Enter T2 afterwards.
- mem_ready never rises, MEM_TIMEOUT=15: FAULT after 15 T1W cycles, mem_err=1. run toggling has no effect. clear returns to IDLE with mem_err=0.
- In EXEC, drive exec_bus_sel=0x000002 → bus_out_sel=0x000002. Drive 0x000003 for 2 cycles → bus_out_sel=0, bus_conflict=1, conflict_count=2.
- exec_done with run=1, halt=0 → T0 on the next cycle. exec_done with halt=1 → IDLE. exec_done while in T0 → ignored.
- Assert clear mid-T1W: outputs 0 immediately, with no clock edge needed. After clear is released with run=1, the fetch restarts at T0.

Source files
------------

// File: rtl/fetch_bus_if.sv
// Fetch-sequencer bus bundle: execute-side requests and memory handshake in,
// one-hot bus-source vector, fetch load strobes and status out.
interface fetch_bus_if;
    logic        run;
    logic        halt;
    logic        mem_ready;
    logic [23:0] exec_bus_sel;
    logic        exec_done;

    logic [23:0] bus_out_sel;
    logic        mar_in;
    logic        inc_pc;
    logic        z_in;
    logic        pc_in;
    logic        mem_read;
    logic        mdr_in;
    logic        ir_in;
    logic        ir_valid;
    logic        exec_start;
    logic        mem_err;
    logic        bus_conflict;
    logic [7:0]  conflict_count;
    logic [2:0]  state;

    // The sequencer itself.
    modport master (
        input  run, halt, mem_ready, exec_bus_sel, exec_done,
        output bus_out_sel, mar_in, inc_pc, z_in, pc_in, mem_read, mdr_in, ir_in,
               ir_valid, exec_start, mem_err, bus_conflict, conflict_count, state
    );

    // The surrounding datapath / execute sequencer.
    modport slave (
        output run, halt, mem_ready, exec_bus_sel, exec_done,
        input  bus_out_sel, mar_in, inc_pc, z_in, pc_in, mem_read, mdr_in, ir_in,
               ir_valid, exec_start, mem_err, bus_conflict, conflict_count, state
    );
endinterface

// File: rtl/fetch_bus_sequencer.sv
// Instruction-fetch control-step sequencer. Owns the one-hot bus-source
// select during fetch, hands it to the execute sequencer in EXEC, times out
// a stalled memory read into a sticky FAULT and polices multi-hot requests.
module fetch_bus_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 15   // T1W cycles before FAULT (1..255)
) (
    input  logic        clock,
    input  logic        clear,
    fetch_bus_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_T0    = 3'd1,
        ST_T1    = 3'd2,
        ST_T1W   = 3'd3,
        ST_T2    = 3'd4,
        ST_EXEC  = 3'd5,
        ST_FAULT = 3'd6
    } state_e;

    localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

    state_e      state_q;
    logic [7:0]  wait_cnt_q;
    logic        exec_start_q;
    logic        mem_err_q;
    logic [7:0]  conflict_count_q;

    logic [23:0] bus_out_sel_d;
    logic        mar_in_d, inc_pc_d, z_in_d, pc_in_d;
    logic        mem_read_d, mdr_in_d, ir_in_d, ir_valid_d;
    logic        multi_hot;
    logic        bus_conflict_d;

    // More than one bit set: clearing the lowest set bit leaves something.
    assign multi_hot = (bus.exec_bus_sel & (bus.exec_bus_sel - 24'd1)) != 24'd0;

    // Moore decode of the control step; only mdr_in and the EXEC bus
    // source look at inputs. Outputs follow state, so clear forces them
    // low immediately through the asynchronous state reset.
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // through this block leaves a signal unassigned (no latches).
        bus_out_sel_d  = '0;
        mar_in_d       = 1'b0;
        inc_pc_d       = 1'b0;
        z_in_d         = 1'b0;
        pc_in_d        = 1'b0;
        mem_read_d     = 1'b0;
        mdr_in_d       = 1'b0;
        ir_in_d        = 1'b0;
        ir_valid_d     = 1'b0;
        bus_conflict_d = 1'b0;
        case (state_q)
            ST_T0: begin
                bus_out_sel_d[20] = 1'b1;   // PCout
                mar_in_d          = 1'b1;
                inc_pc_d          = 1'b1;
                z_in_d            = 1'b1;
            end
            ST_T1: begin
                bus_out_sel_d[19] = 1'b1;   // Zlowout
                pc_in_d           = 1'b1;
            end
            ST_T1W: begin
                mem_read_d = 1'b1;
                mdr_in_d   = bus.mem_ready;
            end
            ST_T2: begin
                bus_out_sel_d[21] = 1'b1;   // MDRout
                ir_in_d           = 1'b1;
            end
            ST_EXEC: begin
                ir_valid_d = 1'b1;
                if (multi_hot) begin
                    bus_conflict_d = 1'b1;
                end else begin
                    bus_out_sel_d = bus.exec_bus_sel;
                end
            end
            default: ;
        endcase
    end

    // Control-step FSM plus wait counter, exec_start pulse, sticky error
    // and saturating conflict counter.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q          <= ST_IDLE;
            wait_cnt_q       <= '0;
            exec_start_q     <= 1'b0;
            mem_err_q        <= 1'b0;
            conflict_count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples
            // the pre-edge values, independent of statement order.
            exec_start_q <= (state_q == ST_T2);
            if (bus_conflict_d && conflict_count_q != 8'hFF) begin
                conflict_count_q <= conflict_count_q + 8'd1;
            end
            case (state_q)
                ST_IDLE: if (bus.run) state_q <= ST_T0;
                ST_T0:   state_q <= ST_T1;
                ST_T1: begin
                    wait_cnt_q <= '0;
                    state_q    <= ST_T1W;
                end
                ST_T1W: begin
                    // A late mem_ready on the timeout cycle still wins.
                    if (bus.mem_ready) begin
                        state_q <= ST_T2;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                        if (wait_cnt_q + 8'd1 == TIMEOUT_C) begin
                            state_q   <= ST_FAULT;
                            mem_err_q <= 1'b1;
                        end
                    end
                end
                ST_T2:   state_q <= ST_EXEC;
                ST_EXEC: begin
                    if (bus.exec_done) begin
                        state_q <= (bus.halt || !bus.run) ? ST_IDLE : ST_T0;
                    end
                end
                ST_FAULT: state_q <= ST_FAULT;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.bus_out_sel    = bus_out_sel_d;
    assign bus.mar_in         = mar_in_d;
    assign bus.inc_pc         = inc_pc_d;
    assign bus.z_in           = z_in_d;
    assign bus.pc_in          = pc_in_d;
    assign bus.mem_read       = mem_read_d;
    assign bus.mdr_in         = mdr_in_d;
    assign bus.ir_in          = ir_in_d;
    assign bus.ir_valid       = ir_valid_d;
    assign bus.bus_conflict   = bus_conflict_d;
    assign bus.exec_start     = exec_start_q;
    assign bus.mem_err        = mem_err_q;
    assign bus.conflict_count = conflict_count_q;
    assign bus.state          = state_q;

endmodule
